survivor_mem: RTL

Circular survivor-decision store between the add-compare-select (ACS) array and the traceback unit of the K=7 Viterbi decoder. Each accepted symbol, the ACS presents one decision bit per trellis state plus the current best state. The block writes that column into a D-deep ring and advances `wr_ptr`. Traceback reads single bits by (time index, state) with fixed one-cycle latency and takes `s_end` from here.

---
 rtl/survivor_mem.sv | 74 +++++++
 1 files changed

// File: rtl/survivor_mem.sv
// Survivor-decision ring between the ACS array and traceback: one column write per symbol,
// single-bit registered read by (time index, state).
module survivor_mem #(
    parameter int K = 7,
    parameter int M = K - 1,
    parameter int D = 40,
    localparam int N = 2**M,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_valid,
    input  logic [N-1:0]  dec_vec,
    input  logic [M-1:0]  best_state,
    input  logic          flush,
    output logic [AW-1:0] wr_ptr,
    output logic [M-1:0]  s_end,
    output logic [AW:0]   fill_count,
    output logic          full,
    input  logic [AW-1:0] tb_time,
    input  logic [M-1:0]  tb_state,
    output logic          tb_surv_bit
);

    logic [N-1:0] mem [D];
    logic [AW:0]  fill_next;
    logic         wr_en;

    assign wr_en = dec_valid && !flush;

    always_comb begin
        fill_next = fill_count;
        if (flush)
            fill_next = '0;
        else if (dec_valid && fill_count < (AW+1)'(D))
            fill_next = fill_count + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            s_end      <= '0;
            fill_count <= '0;
            full       <= 1'b0;
        end else begin
            fill_count <= fill_next;
            full       <= (fill_next == (AW+1)'(D));
            if (flush) begin
                wr_ptr <= '0;
                s_end  <= '0;
            end else if (dec_valid) begin
                wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + AW'(1);
                s_end  <= best_state;
            end
        end
    end

    // Array is not reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr] <= dec_vec;
    end

    // Non-blocking read of the array gives read-first behaviour on a same-slot collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tb_surv_bit <= 1'b0;
        else if (tb_time < AW'(D))
            tb_surv_bit <= mem[tb_time][tb_state];
        else
            tb_surv_bit <= 1'b0;
    end

endmodule
